// File: rtl/scc_pkg.sv
// Shared definitions for the scc test datapath: instruction field layout,
// special encodings, ALU function codes and sequencer state codes.
package scc_pkg;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_FETCH     = 3'd1;
  localparam state_t S_DECODE    = 3'd2;
  localparam state_t S_EXECUTE   = 3'd3;
  localparam state_t S_WRITEBACK = 3'd4;
  localparam state_t S_HALTED    = 3'd5;
  localparam state_t S_ERROR     = 3'd6;

  localparam int MODE_BIT     = 31;
  localparam int FUNC_HI      = 30;
  localparam int FUNC_LO      = 28;
  localparam int IMM_MODE_BIT = 27;
  localparam int SETF_BIT     = 26;
  localparam int RD_HI        = 25;
  localparam int RD_LO        = 22;
  localparam int RS1_HI       = 21;
  localparam int RS1_LO       = 18;
  localparam int RSV_HI       = 17;
  localparam int RSV_LO       = 16;
  localparam int IMM_HI       = 15;
  localparam int RS2_HI       = 3;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic       ALU_MODE_ARITH = 1'b1;
  localparam logic [2:0] FUNC_RSV_LO    = 3'b000;
  localparam logic [2:0] FUNC_ADD       = 3'b001;
  localparam logic [2:0] FUNC_SUB       = 3'b010;
  localparam logic [2:0] FUNC_RSV_HI    = 3'b111;

  localparam int DEFAULT_RESET_PC = 0;

  typedef struct packed {
    logic        alu_mode;
    logic [2:0]  alu_func;
    logic        imm_mode;
    logic        set_flags;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
  } insn_t;

endpackage

// File: rtl/alu_insn_decode.sv
// Combinational instruction decoder: splits the word into ALU/register fields
// and classifies HALT and illegal encodings (HALT takes precedence).
module alu_insn_decode
  import scc_pkg::*;
(
  input  logic [31:0] insn_i,
  output insn_t       fields_o,
  output logic        is_halt_o,
  output logic        is_illegal_o
);

  logic rsv_bad;
  logic func_bad;

  always_comb begin
    fields_o.alu_mode  = insn_i[MODE_BIT];
    fields_o.alu_func  = insn_i[FUNC_HI:FUNC_LO];
    fields_o.imm_mode  = insn_i[IMM_MODE_BIT];
    fields_o.set_flags = insn_i[SETF_BIT];
    fields_o.rd        = insn_i[RD_HI:RD_LO];
    fields_o.rs1       = insn_i[RS1_HI:RS1_LO];
    fields_o.rs2       = insn_i[RS2_HI:0];
    fields_o.imm       = insn_i[IMM_HI:0];
  end

  assign is_halt_o    = (insn_i == HALT_WORD);
  assign rsv_bad      = (insn_i[RSV_HI:RSV_LO] != 2'b00);
  assign func_bad     = (fields_o.alu_mode == ALU_MODE_ARITH) &&
                        ((fields_o.alu_func == FUNC_RSV_LO) || (fields_o.alu_func == FUNC_RSV_HI));
  assign is_illegal_o = !is_halt_o && (rsv_bad || func_bad);

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving the ALU and register file;
// one instruction retires every 3 + (fetch cycles) clocks.
module alu_sequencer
  import scc_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imemReq,
  output logic [PC_W-1:0] imemAddr,
  input  logic            imemValid,
  input  logic [31:0]     imemData,
  output logic [3:0]      rfRaddr1,
  output logic [3:0]      rfRaddr2,
  output logic            aluMode,
  output logic [2:0]      aluFunc,
  output logic            immediateMode,
  output logic [15:0]     immediate,
  input  logic [31:0]     aluResults,
  input  logic [3:0]      aluFlags,
  output logic            rfWe,
  output logic [3:0]      rfWaddr,
  output logic [31:0]     rfWdata,
  output logic [3:0]      flagsQ,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q;
  logic [31:0]     res_q;
  logic [3:0]      capf_q;
  logic [3:0]      flags_q;
  logic [3:0]      waddr_q;
  logic [3:0]      raddr1_q, raddr2_q;

  insn_t fields;
  logic  is_halt;
  logic  is_illegal;
  logic  exec;

  alu_insn_decode u_decode (
    .insn_i       (ir_q),
    .fields_o     (fields),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH:     if (imemValid) state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt)         state_d = S_HALTED;
        else if (is_illegal) state_d = S_ERROR;
        else                 state_d = S_EXECUTE;
      end
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_W'(4);
      end
      S_HALTED, S_ERROR: state_d = state_q;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      res_q    <= '0;
      capf_q   <= '0;
      flags_q  <= '0;
      waddr_q  <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_FETCH && imemValid) ir_q <= imemData;
      // Register addresses are set up one cycle early so the file's read data is ready in EXECUTE.
      if (state_q == S_DECODE && !is_halt && !is_illegal) begin
        raddr1_q <= fields.rs1;
        raddr2_q <= fields.rs2;
      end
      if (state_q == S_EXECUTE) begin
        res_q   <= aluResults;
        capf_q  <= aluFlags;
        waddr_q <= fields.rd;
      end
      if (state_q == S_WRITEBACK && fields.set_flags) flags_q <= capf_q;
    end
  end

  assign exec          = (state_q == S_EXECUTE);
  assign aluMode       = exec & fields.alu_mode;
  assign aluFunc       = exec ? fields.alu_func : 3'b000;
  assign immediateMode = exec & fields.imm_mode;
  assign immediate     = exec ? fields.imm : 16'h0000;

  assign imemReq  = (state_q == S_FETCH);
  assign imemAddr = pc_q;
  assign pc       = pc_q;
  assign rfRaddr1 = raddr1_q;
  assign rfRaddr2 = raddr2_q;
  assign rfWe     = (state_q == S_WRITEBACK);
  assign rfWaddr  = waddr_q;
  assign rfWdata  = res_q;
  assign flagsQ   = flags_q;
  assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign halted   = (state_q == S_HALTED);
  assign illegal  = (state_q == S_ERROR);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: register file + ALU environment, an instruction-level
// program model producing expected writebacks, and directed literal checks.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        imemReq, imemValid;
  logic [15:0] imemAddr, pc, immediate;
  logic [31:0] imemData, aluResults, rfWdata;
  logic [3:0]  rfRaddr1, rfRaddr2, rfWaddr, aluFlags, flagsQ;
  logic        aluMode, immediateMode, rfWe, busy, halted, illegal;
  logic [2:0]  aluFunc;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid), .imemData(imemData),
    .rfRaddr1(rfRaddr1), .rfRaddr2(rfRaddr2),
    .aluMode(aluMode), .aluFunc(aluFunc), .immediateMode(immediateMode), .immediate(immediate),
    .aluResults(aluResults), .aluFlags(aluFlags),
    .rfWe(rfWe), .rfWaddr(rfWaddr), .rfWdata(rfWdata), .flagsQ(flagsQ),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
  );

  // ALU: mode0 passes op2; mode1 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 SLL.
  // Flags are {N, Z, C, V}; C is carry-out for ADD and borrow for SUB.
  function automatic logic [35:0] alu_f(logic mode, logic [2:0] fn, logic [31:0] a, logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    if (!mode) r = b;
    else begin
      case (fn)
        3'b001: begin
          w = {1'b0, a} + {1'b0, b};
          r = w[31:0]; c = w[32];
          v = (a[31] == b[31]) && (r[31] != a[31]);
        end
        3'b010: begin
          r = a - b; c = (a < b);
          v = (a[31] != b[31]) && (r[31] != a[31]);
        end
        3'b011: r = a & b;
        3'b100: r = a | b;
        3'b101: r = a ^ b;
        3'b110: r = a << b[4:0];
        default: r = '0;
      endcase
    end
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  logic [31:0] rf [16] = '{32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                           32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

  always @(posedge clk) if (rfWe) rf[rfWaddr] <= rfWdata;

  always_comb begin
    logic [35:0] fr;
    fr = alu_f(aluMode, aluFunc, rf[rfRaddr1], immediateMode ? {16'h0000, immediate} : rf[rfRaddr2]);
    aluFlags   = fr[35:32];
    aluResults = fr[31:0];
  end

  logic [31:0] imem [64];
  int          dly  [64];
  bit          force_valid;

  // Instruction memory: answers a request after dly[] extra cycles.
  initial begin
    int cnt;
    int idx;
    cnt = 0;
    imemValid = 1'b0;
    imemData  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      idx = int'(imemAddr[7:2]);
      if (force_valid) begin
        imemValid = 1'b1;
        imemData  = 32'h9FC0_0001;
      end else if (imemReq) begin
        if (cnt >= dly[idx]) begin
          imemValid = 1'b1; imemData = imem[idx]; cnt = 0;
        end else begin
          imemValid = 1'b0; imemData = 32'hDEAD_BEEF; cnt++;
        end
      end else begin
        imemValid = 1'b0; cnt = 0;
      end
    end
  end

  typedef struct {
    int          kind;   // 0 write, 1 halt, 2 illegal
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [15:0] pc;
    logic [3:0]  fb;
    int          lat;
  } rec_t;

  rec_t       q[$];
  logic [3:0] exp_final_flags;
  int         nvec = 0;
  int         nerr = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Runs the program in imem from pc 0 with flags cleared, as after reset.
  task automatic model_run();
    logic [31:0] mrf [16];
    logic [31:0] w, a, b;
    logic [35:0] fr;
    logic [3:0]  mf;
    logic [15:0] p;
    rec_t        rc;
    mrf = rf; mf = 4'h0; p = 16'h0000;
    q.delete();
    for (int k = 0; k < 64; k++) begin
      w = imem[p[7:2]];
      rc.pc = p; rc.fb = mf; rc.wa = 4'h0; rc.wd = 32'h0; rc.lat = dly[p[7:2]] + 4;
      if (w == 32'hFFFF_FFFF) begin
        rc.kind = 1; q.push_back(rc); break;
      end
      if (w[17:16] != 2'b00 || (w[31] && (w[30:28] == 3'd0 || w[30:28] == 3'd7))) begin
        rc.kind = 2; q.push_back(rc); break;
      end
      a = mrf[w[21:18]];
      b = w[27] ? {16'h0000, w[15:0]} : mrf[w[3:0]];
      fr = alu_f(w[31], w[30:28], a, b);
      rc.kind = 0; rc.wa = w[25:22]; rc.wd = fr[31:0];
      q.push_back(rc);
      mrf[w[25:22]] = fr[31:0];
      if (w[26]) mf = fr[35:32];
      p = p + 16'd4;
    end
    exp_final_flags = mf;
  endtask

  // Compare process: checks every cycle against the head of the model queue.
  initial begin
    int   cyc, req_cyc;
    logic prev_req, prev_halt, prev_ill;
    rec_t r;
    cyc = 0; req_cyc = 0; prev_req = 1'b0; prev_halt = 1'b0; prev_ill = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (imemReq && !prev_req) req_cyc = cyc;
      if (imemReq && q.size() > 0) check("imemAddr", {16'h0, imemAddr}, {16'h0, q[0].pc});
      if (!busy) check("idle_alu_ctrl", {11'h0, rfWe, aluMode, aluFunc, immediateMode, immediate}, 32'h0);
      if (rfWe) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_write: rfWaddr %0d rfWdata %h, required no write", rfWaddr, rfWdata);
        end else begin
          r = q.pop_front();
          check("wb_kind", 32'(r.kind), 32'd0);
          check("rfWaddr", {28'h0, rfWaddr}, {28'h0, r.wa});
          check("rfWdata", rfWdata, r.wd);
          check("wb_pc", {16'h0, pc}, {16'h0, r.pc});
          check("flags_before_wb", {28'h0, flagsQ}, {28'h0, r.fb});
          check("latency", 32'(cyc - req_cyc + 1), 32'(r.lat));
        end
      end
      if ((halted && !prev_halt) || (illegal && !prev_ill)) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_stop: halted %b illegal %b, required still running", halted, illegal);
        end else begin
          r = q.pop_front();
          check("stop_kind", 32'(r.kind), halted ? 32'd1 : 32'd2);
          check("stop_pc", {16'h0, pc}, {16'h0, r.pc});
        end
      end
      prev_req = imemReq; prev_halt = halted; prev_ill = illegal;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; force_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(string nm, int budget);
    int n;
    n = 0;
    while (!(halted || illegal) && n < budget) begin
      tick(); n++;
    end
    if (!(halted || illegal)) begin
      nvec++; nerr++;
      $display("FAIL %s: no halt/illegal after %0d cycles, required one", nm, budget);
    end
    tick();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'hFFFF_FFFF; dly[i] = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; force_valid = 1'b0;
    clear_prog();
    do_reset();
    check("rst_pc", {16'h0, pc}, 32'h0);
    check("rst_status", {27'h0, busy, imemReq, halted, illegal, rfWe}, 32'h0);
    check("rst_regs", {16'h0, flagsQ, rfWaddr, rfRaddr1, rfRaddr2}, 32'h0);

    // Run A: ADD imm r1=r0+5, SUB r2=r5-1 with flags, HALT at pc 8.
    imem[0] = 32'h9840_0005;
    imem[1] = 32'hAC94_0001;
    model_run();
    pulse_start();
    check("req_after_start", {31'h0, imemReq}, 32'd1);
    tick(3);
    check("A_rfWe_cycle4", {31'h0, rfWe}, 32'd1);
    check("A_rfWaddr", {28'h0, rfWaddr}, 32'd1);
    check("A_rfWdata", rfWdata, 32'd8);
    tick();
    check("A_pc_after", {16'h0, pc}, 32'd4);
    wait_done("runA", 100);
    check("A_halted", {31'h0, halted}, 32'd1);
    check("A_halt_pc", {16'h0, pc}, 32'd8);
    check("A_flagsN", {28'h0, flagsQ}, 32'hA);
    check("A_r2", rf[2], 32'hFFFF_FFFF);
    check("A_queue_empty", 32'(q.size()), 32'd0);
    force_valid = 1'b1;
    pulse_start();
    tick(3);
    force_valid = 1'b0;
    tick();
    check("A_still_halted", {28'h0, halted, busy, illegal, imemReq}, 32'h8);
    check("A_halt_pc_hold", {16'h0, pc}, 32'd8);

    // Run B: SUB with flags, SUB without flags, slow fetches, read-after-write, reserved bits set.
    do_reset();
    clear_prog();
    imem[0] = 32'hAD9C_0001;
    imem[1] = 32'hA9C0_0001;
    imem[2] = 32'h9100_0001; dly[2] = 5;
    imem[3] = 32'h9150_0001; dly[3] = 4;
    imem[4] = 32'h0001_0000;
    model_run();
    pulse_start();
    wait_done("runB", 200);
    check("B_illegal", {30'h0, illegal, halted}, 32'h2);
    check("B_err_pc", {16'h0, pc}, 32'd16);
    check("B_flags_kept", {28'h0, flagsQ}, 32'hA);
    check("B_flags_model", {28'h0, flagsQ}, {28'h0, exp_final_flags});
    check("B_r7", rf[7], 32'd2);
    check("B_r4", rf[4], 32'd11);
    check("B_r5_raw", rf[5], 32'd19);
    check("B_queue_empty", 32'(q.size()), 32'd0);

    // Run C: aluMode=1 with aluFunc=111 is illegal.
    do_reset();
    clear_prog();
    imem[0] = 32'hF040_0000;
    model_run();
    pulse_start();
    wait_done("runC", 50);
    check("C_illegal", {30'h0, illegal, halted}, 32'h2);
    check("C_pc", {16'h0, pc}, 32'd0);
    check("C_queue_empty", 32'(q.size()), 32'd0);

    // Run D: reset in the middle of a slow fetch at pc 4, with imemValid right after.
    do_reset();
    clear_prog();
    imem[0] = 32'h9A00_0002;
    imem[1] = 32'h9A00_0002; dly[1] = 3;
    model_run();
    pulse_start();
    tick(4);
    check("D_fetch_pc4", {15'h0, imemReq, pc}, 32'h0001_0004);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    force_valid = 1'b1;
    q.delete();
    check("D_rst_pc", {16'h0, pc}, 32'h0);
    tick(3);
    force_valid = 1'b0;
    check("D_idle_status", {27'h0, busy, imemReq, halted, illegal, rfWe}, 32'h0);
    check("D_idle_regs", {16'h0, flagsQ, rfWaddr, rfRaddr1, rfRaddr2}, 32'h0);
    check("D_idle_wdata", rfWdata, 32'h0);
    check("D_idle_pc", {16'h0, pc}, 32'h0);
    check("D_r8", rf[8], 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
